// File: rtl/cntry_road_sensor_if.sv
// Country-road sensor bundle: loop detector and lamp feedback in,
// car-present request and diagnostics out.
interface cntry_road_sensor_if;
  logic       loop_raw;
  logic [1:0] cntry_road_signal;
  logic       x;
  logic [7:0] car_count;
  logic [1:0] state_out;

  modport master (
    output loop_raw,
    output cntry_road_signal,
    input  x,
    input  car_count,
    input  state_out
  );

  modport slave (
    input  loop_raw,
    input  cntry_road_signal,
    output x,
    output car_count,
    output state_out
  );
endinterface

// File: rtl/cntry_road_sensor.sv
// Country-road car sensor: debounces the loop, latches the request
// until green, then holds it while cars keep coming (bounded).
module cntry_road_sensor #(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned CLEAR_CYC    = 3,
  parameter int unsigned MAX_HOLD     = 16,
  parameter logic [1:0]  GREEN_CODE   = 2'b10
) (
  input  logic                 clk,
  input  logic                 reset,
  cntry_road_sensor_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    REQUEST  = 2'd2,
    SERVED   = 2'd3
  } state_t;

  localparam logic [7:0] DEB_C = 8'(DEBOUNCE_CYC);
  localparam logic [7:0] CLR_C = 8'(CLEAR_CYC);
  localparam logic [7:0] HLD_C = 8'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [7:0] deb_q, deb_d;
  logic [7:0] clr_q, clr_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] cnt_q, cnt_d;
  logic       inc;
  logic       green;
  logic [7:0] deb_nx;
  logic [7:0] clr_nx;
  logic [7:0] hold_nx;

  assign green   = (bus.cntry_road_signal == GREEN_CODE);
  assign deb_nx  = deb_q + 8'd1;
  assign clr_nx  = clr_q + 8'd1;
  assign hold_nx = hold_q + 8'd1;

  // State register and counters; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      deb_q   <= '0;
      clr_q   <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      clr_q   <= clr_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter updates and the car-count bump.
  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    clr_d   = clr_q;
    hold_d  = hold_q;
    inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        clr_d  = '0;
        hold_d = '0;
        if (bus.loop_raw) begin
          if (DEB_C == 8'd1) begin
            state_d = REQUEST;
            deb_d   = '0;
            inc     = 1'b1;
          end else begin
            state_d = DEBOUNCE;
            deb_d   = 8'd1;
          end
        end else begin
          deb_d = '0;
        end
      end
      DEBOUNCE: begin
        if (!bus.loop_raw) begin
          state_d = IDLE;
          deb_d   = '0;
        end else if (deb_nx == DEB_C) begin
          state_d = REQUEST;
          deb_d   = '0;
          inc     = 1'b1;
        end else begin
          deb_d = deb_nx;
        end
      end
      REQUEST: begin
        if (green) begin
          state_d = SERVED;
          clr_d   = '0;
          hold_d  = '0;
        end
      end
      SERVED: begin
        hold_d = hold_nx;
        if (!green) begin
          state_d = IDLE;
        end else if (hold_nx == HLD_C) begin
          state_d = IDLE;
        end else if (!bus.loop_raw) begin
          clr_d = clr_nx;
          if (clr_nx == CLR_C) begin
            state_d = IDLE;
          end
        end else begin
          clr_d = '0;
        end
        if (state_d == IDLE) begin
          clr_d  = '0;
          hold_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Saturating vehicle counter.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign bus.x         = (state_q == REQUEST) || (state_q == SERVED);
  assign bus.car_count = cnt_q;
  assign bus.state_out = state_q;

endmodule

// File: tb/tb_cntry_road_sensor.sv
// Scoreboard bench for cntry_road_sensor: directed steps push expected
// state/count, a negedge monitor pops and compares.
module tb_cntry_road_sensor;

  localparam logic [1:0] G   = 2'b10;
  localparam logic [1:0] RED = 2'b00;
  localparam logic [1:0] YEL = 2'b01;

  typedef struct {
    logic [1:0] st;
    logic       x;
    logic [7:0] cnt;
    int         id;
  } exp_t;

  logic clk;
  logic reset;
  cntry_road_sensor_if bus ();

  cntry_road_sensor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   step_id = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: outputs are registered, so compare on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_chk++;
      if (bus.state_out !== e.st || bus.x !== e.x ||
          bus.car_count !== e.cnt) begin
        n_fail++;
        $display("FAIL step%0d: got st=%0d x=%0b cnt=%0d want st=%0d x=%0b cnt=%0d",
                 e.id, bus.state_out, bus.x, bus.car_count,
                 e.st, e.x, e.cnt);
      end
    end
  end

  task automatic step(input logic rst, input logic lp,
                      input logic [1:0] sg, input logic [1:0] es,
                      input int ec);
    exp_t e;
    @(negedge clk);
    reset = rst;
    bus.loop_raw = lp;
    bus.cntry_road_signal = sg;
    @(posedge clk);
    step_id++;
    e.st  = es;
    e.x   = (es == 2'd2) || (es == 2'd3);
    e.cnt = 8'(ec);
    e.id  = step_id;
    sb.push_back(e);
  endtask

  initial begin
    int c;
    reset = 1'b1;
    bus.loop_raw = 1'b1;
    bus.cntry_road_signal = G;

    // Reset held two edges with car and green present.
    step(1, 1, G, 0, 0);
    step(1, 1, G, 0, 0);

    // Clean car, signal red.
    step(0, 1, RED, 1, 0);
    step(0, 1, RED, 1, 0);
    step(0, 1, RED, 1, 0);
    step(0, 1, RED, 2, 1);
    for (int i = 0; i < 20; i++) step(0, 1, RED, 2, 1);

    // Reset out of REQUEST.
    step(1, 0, RED, 0, 0);

    // Bounce: 1,1,1,0,1,1,1,1.
    step(0, 1, RED, 1, 0);
    step(0, 1, RED, 1, 0);
    step(0, 1, RED, 1, 0);
    step(0, 0, RED, 0, 0);
    step(0, 1, RED, 1, 0);
    step(0, 1, RED, 1, 0);
    step(0, 1, RED, 1, 0);
    step(0, 1, RED, 2, 1);

    // Served: two lows, five highs (clear count restarts), three lows.
    step(0, 0, G, 3, 1);
    step(0, 0, G, 3, 1);
    step(0, 0, G, 3, 1);
    for (int i = 0; i < 5; i++) step(0, 1, G, 3, 1);
    step(0, 0, G, 3, 1);
    step(0, 0, G, 3, 1);
    step(0, 0, G, 0, 1);
    step(0, 0, RED, 0, 1);

    // Hold cap: new car, then green with car present throughout.
    step(0, 1, RED, 1, 1);
    step(0, 1, RED, 1, 1);
    step(0, 1, RED, 1, 1);
    step(0, 1, RED, 2, 2);
    step(0, 1, G, 3, 2);
    for (int i = 0; i < 15; i++) step(0, 1, G, 3, 2);
    step(0, 1, G, 0, 2);
    step(0, 1, G, 1, 2);
    step(0, 1, G, 1, 2);
    step(0, 1, G, 1, 2);
    step(0, 1, G, 2, 3);
    step(0, 1, G, 3, 3);

    // Green withdrawn mid-SERVED.
    step(0, 1, YEL, 0, 3);
    step(0, 0, YEL, 0, 3);

    // Reset mid-debounce.
    step(0, 1, RED, 1, 3);
    step(0, 1, RED, 1, 3);
    step(1, 1, RED, 0, 0);

    // 260 full car cycles; count saturates at 255.
    for (int n = 1; n <= 260; n++) begin
      c = (n > 255) ? 255 : n;
      step(0, 1, RED, 1, (n - 1 > 255) ? 255 : n - 1);
      step(0, 1, RED, 1, (n - 1 > 255) ? 255 : n - 1);
      step(0, 1, RED, 1, (n - 1 > 255) ? 255 : n - 1);
      step(0, 1, RED, 2, c);
      step(0, 1, G, 3, c);
      step(0, 1, YEL, 0, c);
    end

    // Drain the scoreboard with a bound.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
